branch_queue: RTL and testbench

BRANCH_QUEUE -- requirements
Module: branch_queue

---
 rtl/branch_queue.sv | 160 ++++++++++++++++
 tb/tb_branch_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_queue.sv
// In-order branch queue: one outstanding branch per hardware thread, resolved out of order
// by execute, presented in allocation order to the PC stage for redirect or auto-retire.
module branch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int TID_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid_i,
  input  logic [TID_W-1:0] alloc_thread_id_i,
  output logic             alloc_ready_o,
  input  logic             res_valid_i,
  input  logic [TID_W-1:0] res_thread_id_i,
  input  logic             res_taken_i,
  input  logic [XLEN-1:0]  res_target_i,
  output logic             branch_fifo_empty_o,
  output logic [TID_W-1:0] br_thread_id_o,
  output logic             br_valid_o,
  output logic             br_true_o,
  output logic [XLEN-1:0]  br_pc_o,
  input  logic             br_ack_i,
  output logic [TID_W:0]   count_o,
  output logic             err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = TID_W + 1;

  logic [TID_W-1:0] ent_tid   [DEPTH];
  logic [XLEN-1:0]  ent_tgt   [DEPTH];
  logic [DEPTH-1:0] ent_pend;
  logic [DEPTH-1:0] ent_res;
  logic [DEPTH-1:0] ent_taken;

  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] tail_idx;
  logic             head_wrap;
  logic             tail_wrap;
  logic             err_q;

  logic [CNT_W-1:0] count;
  logic             head_occ;
  logic             head_valid;
  logic             head_rt;
  logic             alloc_hit;
  logic             res_hit;
  logic [PTR_W-1:0] res_idx;
  logic             alloc_ready;
  logic             alloc_fire;
  logic             res_fire;
  logic             pop;
  logic             proto_err;

  // Occupancy from index difference; the wrap bits tell full apart from empty.
  always_comb begin
    if (head_wrap == tail_wrap) begin
      count = CNT_W'(tail_idx) - CNT_W'(head_idx);
    end else begin
      count = CNT_W'(DEPTH) - CNT_W'(head_idx) + CNT_W'(tail_idx);
    end
  end

  // At most one occupied entry per thread, so the first match is the only match.
  always_comb begin
    logic [PTR_W-1:0] idx;
    alloc_hit = 1'b0;
    res_hit   = 1'b0;
    res_idx   = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = PTR_W'(i);
      if (ent_pend[idx] && (ent_tid[idx] == alloc_thread_id_i)) begin
        alloc_hit = 1'b1;
      end
      if (!res_hit && ent_pend[idx] && (ent_tid[idx] == res_thread_id_i)) begin
        res_hit = 1'b1;
        res_idx = idx;
      end
    end
  end

  always_comb begin
    head_occ    = ent_pend[head_idx];
    head_valid  = head_occ && ent_res[head_idx];
    head_rt     = head_valid && ent_taken[head_idx];
    alloc_ready = (count < CNT_W'(DEPTH)) && !alloc_hit;
    alloc_fire  = alloc_valid_i && alloc_ready;
    res_fire    = res_valid_i && res_hit && !ent_res[res_idx];
    // Not-taken heads retire on their own; taken heads wait for the PC stage.
    pop         = head_valid && (!ent_taken[head_idx] || br_ack_i);
    proto_err   = (alloc_valid_i && !alloc_ready)
                || (res_valid_i && (!res_hit || ent_res[res_idx]))
                || (br_ack_i && !head_rt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_idx  <= '0;
      tail_idx  <= '0;
      head_wrap <= 1'b0;
      tail_wrap <= 1'b0;
      ent_pend  <= '0;
      ent_res   <= '0;
      ent_taken <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_tid[PTR_W'(i)] <= '0;
        ent_tgt[PTR_W'(i)] <= '0;
      end
    end else begin
      if (proto_err) begin
        err_q <= 1'b1;
      end

      // A resolving entry is never the popping head (pop needs it already resolved)
      // nor the tail slot (that slot is free unless full, and alloc is refused when full).
      if (res_fire) begin
        ent_res[res_idx]   <= 1'b1;
        ent_taken[res_idx] <= res_taken_i;
        ent_tgt[res_idx]   <= res_target_i;
      end

      if (pop) begin
        ent_pend[head_idx] <= 1'b0;
        ent_res[head_idx]  <= 1'b0;
        if (head_idx == PTR_W'(DEPTH - 1)) begin
          head_idx  <= '0;
          head_wrap <= ~head_wrap;
        end else begin
          head_idx <= head_idx + 1'b1;
        end
      end

      if (alloc_fire) begin
        ent_pend[tail_idx]  <= 1'b1;
        ent_res[tail_idx]   <= 1'b0;
        ent_taken[tail_idx] <= 1'b0;
        ent_tid[tail_idx]   <= alloc_thread_id_i;
        ent_tgt[tail_idx]   <= '0;
        if (tail_idx == PTR_W'(DEPTH - 1)) begin
          tail_idx  <= '0;
          tail_wrap <= ~tail_wrap;
        end else begin
          tail_idx <= tail_idx + 1'b1;
        end
      end
    end
  end

  assign alloc_ready_o       = alloc_ready;
  assign branch_fifo_empty_o = (count == '0);
  assign br_thread_id_o      = head_occ ? ent_tid[head_idx] : '0;
  assign br_valid_o          = head_valid;
  assign br_true_o           = head_rt;
  assign br_pc_o             = head_valid ? ent_tgt[head_idx] : '0;
  assign count_o             = count;
  assign err_o               = err_q;

endmodule

// File: tb/tb_branch_queue.sv
// Directed bench for branch_queue: per-scenario tasks with hand-computed expectations.
module tb_branch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_valid_i = 1'b0;
  logic [2:0]  alloc_thread_id_i = '0;
  logic        alloc_ready_o;
  logic        res_valid_i = 1'b0;
  logic [2:0]  res_thread_id_i = '0;
  logic        res_taken_i = 1'b0;
  logic [31:0] res_target_i = '0;
  logic        branch_fifo_empty_o;
  logic [2:0]  br_thread_id_o;
  logic        br_valid_o;
  logic        br_true_o;
  logic [31:0] br_pc_o;
  logic        br_ack_i = 1'b0;
  logic [3:0]  count_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  branch_queue #(.XLEN(32), .DEPTH(8), .TID_W(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .alloc_valid_i       (alloc_valid_i),
    .alloc_thread_id_i   (alloc_thread_id_i),
    .alloc_ready_o       (alloc_ready_o),
    .res_valid_i         (res_valid_i),
    .res_thread_id_i     (res_thread_id_i),
    .res_taken_i         (res_taken_i),
    .res_target_i        (res_target_i),
    .branch_fifo_empty_o (branch_fifo_empty_o),
    .br_thread_id_o      (br_thread_id_o),
    .br_valid_o          (br_valid_o),
    .br_true_o           (br_true_o),
    .br_pc_o             (br_pc_o),
    .br_ack_i            (br_ack_i),
    .count_o             (count_o),
    .err_o               (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid_i = 1'b0;
    res_valid_i   = 1'b0;
    res_taken_i   = 1'b0;
    res_target_i  = '0;
    br_ack_i      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic do_alloc(input logic [2:0] tid);
    alloc_valid_i = 1'b1;
    alloc_thread_id_i = tid;
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic do_res(input logic [2:0] tid, input logic taken, input logic [31:0] tgt);
    res_valid_i = 1'b1;
    res_thread_id_i = tid;
    res_taken_i = taken;
    res_target_i = tgt;
    tick();
    clear_inputs();
  endtask

  task automatic do_ack();
    br_ack_i = 1'b1;
    tick();
    br_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    checks++; if (branch_fifo_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", branch_fifo_empty_o); end
    checks++; if ({br_valid_o, br_true_o} !== 2'b00) begin errors++; $display("FAIL reset_valid_true: got %b expected 00", {br_valid_o, br_true_o}); end
    checks++; if (br_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", br_pc_o); end
    checks++; if (br_thread_id_o !== 3'd0) begin errors++; $display("FAIL reset_tid: got %0d expected 0", br_thread_id_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
    alloc_thread_id_i = 3'd0;
    #1;
    checks++; if (alloc_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", alloc_ready_o); end
  endtask

  task automatic test_taken();
    do_alloc(3'd2);
    checks++; if ({branch_fifo_empty_o, count_o} !== {1'b0, 4'd1}) begin errors++; $display("FAIL taken_alloc: got empty=%b count=%0d expected empty=0 count=1", branch_fifo_empty_o, count_o); end
    checks++; if ({br_thread_id_o, br_valid_o} !== {3'd2, 1'b0}) begin errors++; $display("FAIL taken_head_unres: got tid=%0d valid=%b expected tid=2 valid=0", br_thread_id_o, br_valid_o); end
    do_res(3'd2, 1'b1, 32'h100);
    checks++; if ({br_valid_o, br_true_o, br_pc_o} !== {2'b11, 32'h100}) begin errors++; $display("FAIL taken_resolved: got v=%b t=%b pc=%h expected v=1 t=1 pc=100", br_valid_o, br_true_o, br_pc_o); end
    tick(); tick(); tick();
    checks++; if ({br_valid_o, br_true_o, br_pc_o, count_o} !== {2'b11, 32'h100, 4'd1}) begin errors++; $display("FAIL taken_held: got v=%b t=%b pc=%h count=%0d expected v=1 t=1 pc=100 count=1", br_valid_o, br_true_o, br_pc_o, count_o); end
    do_ack();
    checks++; if ({branch_fifo_empty_o, count_o, br_valid_o} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL taken_ack_pop: got empty=%b count=%0d valid=%b expected empty=1 count=0 valid=0", branch_fifo_empty_o, count_o, br_valid_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL taken_err: got %b expected 0", err_o); end
  endtask

  task automatic test_not_taken();
    do_alloc(3'd5);
    do_res(3'd5, 1'b0, 32'h200);
    checks++; if ({br_valid_o, br_true_o, br_thread_id_o, br_pc_o} !== {2'b10, 3'd5, 32'h200}) begin errors++; $display("FAIL nt_present: got v=%b t=%b tid=%0d pc=%h expected v=1 t=0 tid=5 pc=200", br_valid_o, br_true_o, br_thread_id_o, br_pc_o); end
    tick();
    checks++; if ({branch_fifo_empty_o, br_valid_o, br_pc_o} !== {2'b10, 32'h0}) begin errors++; $display("FAIL nt_autopop: got empty=%b valid=%b pc=%h expected empty=1 valid=0 pc=0", branch_fifo_empty_o, br_valid_o, br_pc_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL nt_err: got %b expected 0", err_o); end
  endtask

  task automatic test_back_to_back();
    do_alloc(3'd6);
    do_res(3'd6, 1'b1, 32'h60);
    br_ack_i = 1'b1;
    alloc_valid_i = 1'b1;
    alloc_thread_id_i = 3'd7;
    tick();
    clear_inputs();
    checks++; if ({count_o, br_thread_id_o, br_valid_o} !== {4'd1, 3'd7, 1'b0}) begin errors++; $display("FAIL b2b_alloc_pop: got count=%0d tid=%0d valid=%b expected count=1 tid=7 valid=0", count_o, br_thread_id_o, br_valid_o); end
    // same-thread alloc and resolve: resolve applies to the existing entry, alloc refused
    alloc_valid_i = 1'b1;
    alloc_thread_id_i = 3'd7;
    res_valid_i = 1'b1;
    res_thread_id_i = 3'd7;
    res_taken_i = 1'b1;
    res_target_i = 32'h70;
    tick();
    clear_inputs();
    checks++; if ({count_o, br_valid_o, br_true_o, br_pc_o} !== {4'd1, 2'b11, 32'h70}) begin errors++; $display("FAIL b2b_same_tid: got count=%0d v=%b t=%b pc=%h expected count=1 v=1 t=1 pc=70", count_o, br_valid_o, br_true_o, br_pc_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL b2b_same_tid_err: got %b expected 1", err_o); end
    do_reset();
  endtask

  task automatic test_full();
    int waited;
    for (int i = 0; i < 8; i++) do_alloc(3'(i));
    alloc_thread_id_i = 3'd0;
    #1;
    checks++; if ({count_o, alloc_ready_o} !== {4'd8, 1'b0}) begin errors++; $display("FAIL full_state: got count=%0d ready=%b expected count=8 ready=0", count_o, alloc_ready_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_err_pre: got %b expected 0", err_o); end
    do_alloc(3'd0);
    checks++; if ({count_o, err_o} !== {4'd8, 1'b1}) begin errors++; $display("FAIL full_ninth: got count=%0d err=%b expected count=8 err=1", count_o, err_o); end
    do_res(3'd0, 1'b1, 32'h40);
    checks++; if ({br_thread_id_o, br_valid_o, br_pc_o} !== {3'd0, 1'b1, 32'h40}) begin errors++; $display("FAIL full_head0: got tid=%0d valid=%b pc=%h expected tid=0 valid=1 pc=40", br_thread_id_o, br_valid_o, br_pc_o); end
    do_ack();
    checks++; if ({count_o, br_thread_id_o} !== {4'd7, 3'd1}) begin errors++; $display("FAIL full_pop: got count=%0d tid=%0d expected count=7 tid=1", count_o, br_thread_id_o); end
    alloc_valid_i = 1'b1;
    alloc_thread_id_i = 3'd0;
    #1;
    checks++; if (alloc_ready_o !== 1'b1) begin errors++; $display("FAIL full_realloc_ready: got %b expected 1", alloc_ready_o); end
    tick();
    alloc_valid_i = 1'b0;
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_wrap_count: got %0d expected 8", count_o); end
    do_res(3'd0, 1'b1, 32'h80);
    for (int i = 1; i < 8; i++) do_res(3'(i), 1'b0, 32'h0);
    waited = 0;
    while (count_o !== 4'd1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL full_drain_timeout: got count=%0d expected 1", count_o); end
    checks++; if ({br_thread_id_o, br_valid_o, br_true_o, br_pc_o} !== {3'd0, 2'b11, 32'h80}) begin errors++; $display("FAIL full_wrapped_head: got tid=%0d v=%b t=%b pc=%h expected tid=0 v=1 t=1 pc=80", br_thread_id_o, br_valid_o, br_true_o, br_pc_o); end
    do_ack();
    checks++; if (branch_fifo_empty_o !== 1'b1) begin errors++; $display("FAIL full_final_empty: got %b expected 1", branch_fifo_empty_o); end
    do_reset();
  endtask

  task automatic test_reorder();
    do_alloc(3'd1);
    do_alloc(3'd3);
    do_res(3'd3, 1'b1, 32'h300);
    checks++; if ({br_thread_id_o, br_valid_o, count_o} !== {3'd1, 1'b0, 4'd2}) begin errors++; $display("FAIL reorder_blocked: got tid=%0d valid=%b count=%0d expected tid=1 valid=0 count=2", br_thread_id_o, br_valid_o, count_o); end
    do_res(3'd1, 1'b0, 32'h10);
    checks++; if ({br_thread_id_o, br_valid_o, br_true_o} !== {3'd1, 2'b10}) begin errors++; $display("FAIL reorder_head1: got tid=%0d v=%b t=%b expected tid=1 v=1 t=0", br_thread_id_o, br_valid_o, br_true_o); end
    tick();
    checks++; if ({br_thread_id_o, br_valid_o, br_true_o, br_pc_o, count_o} !== {3'd3, 2'b11, 32'h300, 4'd1}) begin errors++; $display("FAIL reorder_head3: got tid=%0d v=%b t=%b pc=%h count=%0d expected tid=3 v=1 t=1 pc=300 count=1", br_thread_id_o, br_valid_o, br_true_o, br_pc_o, count_o); end
    do_ack();
    checks++; if ({branch_fifo_empty_o, err_o} !== 2'b10) begin errors++; $display("FAIL reorder_done: got empty=%b err=%b expected empty=1 err=0", branch_fifo_empty_o, err_o); end
  endtask

  task automatic test_errors();
    do_res(3'd2, 1'b1, 32'h22);
    checks++; if ({err_o, branch_fifo_empty_o, br_valid_o} !== 3'b110) begin errors++; $display("FAIL err_orphan_res: got err=%b empty=%b valid=%b expected err=1 empty=1 valid=0", err_o, branch_fifo_empty_o, br_valid_o); end
    do_reset();
    do_alloc(3'd4);
    alloc_thread_id_i = 3'd4;
    #1;
    checks++; if (alloc_ready_o !== 1'b0) begin errors++; $display("FAIL err_dup_ready: got %b expected 0", alloc_ready_o); end
    do_alloc(3'd4);
    checks++; if ({err_o, count_o} !== {1'b1, 4'd1}) begin errors++; $display("FAIL err_dup_alloc: got err=%b count=%0d expected err=1 count=1", err_o, count_o); end
    do_ack();
    checks++; if ({err_o, count_o, br_thread_id_o} !== {1'b1, 4'd1, 3'd4}) begin errors++; $display("FAIL err_bad_ack: got err=%b count=%0d tid=%0d expected err=1 count=1 tid=4", err_o, count_o, br_thread_id_o); end
    do_res(3'd4, 1'b1, 32'h44);
    do_res(3'd4, 1'b0, 32'h99);
    checks++; if ({br_valid_o, br_true_o, br_pc_o} !== {2'b11, 32'h44}) begin errors++; $display("FAIL err_double_res: got v=%b t=%b pc=%h expected v=1 t=1 pc=44", br_valid_o, br_true_o, br_pc_o); end
    do_reset();
  endtask

  task automatic test_reset_full();
    for (int i = 0; i < 8; i++) do_alloc(3'(i));
    do_alloc(3'd2);
    checks++; if ({count_o, err_o} !== {4'd8, 1'b1}) begin errors++; $display("FAIL rstfull_pre: got count=%0d err=%b expected count=8 err=1", count_o, err_o); end
    rst = 1'b0;
    alloc_valid_i = 1'b1;
    alloc_thread_id_i = 3'd0;
    res_valid_i = 1'b1;
    res_thread_id_i = 3'd0;
    res_taken_i = 1'b1;
    br_ack_i = 1'b1;
    tick();
    rst = 1'b1;
    clear_inputs();
    checks++; if ({branch_fifo_empty_o, count_o, err_o} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL rstfull_post: got empty=%b count=%0d err=%b expected empty=1 count=0 err=0", branch_fifo_empty_o, count_o, err_o); end
    checks++; if ({br_valid_o, br_true_o, br_thread_id_o} !== {2'b00, 3'd0}) begin errors++; $display("FAIL rstfull_head: got v=%b t=%b tid=%0d expected v=0 t=0 tid=0", br_valid_o, br_true_o, br_thread_id_o); end
    tick();
    checks++; if ({branch_fifo_empty_o, alloc_ready_o} !== 2'b11) begin errors++; $display("FAIL rstfull_ready: got empty=%b ready=%b expected empty=1 ready=1", branch_fifo_empty_o, alloc_ready_o); end
  endtask

  initial begin
    test_reset();
    test_taken();
    test_not_taken();
    test_back_to_back();
    test_full();
    test_reorder();
    test_errors();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
